// File: rtl/rnd_pkg.sv
// Shared types and constants for the significand rounder: rounding-mode
// encoding, LSB positions per precision, and the per-stage payloads.
package rnd_pkg;

   typedef enum logic [1:0] {
      RNE = 2'b00,
      RZ  = 2'b01,
      RU  = 2'b10,
      RD  = 2'b11
   } rm_t;

   localparam int SIGW   = 53;
   localparam int SGW    = 24;
   localparam int LSB_DB = 3;
   localparam int LSB_SG = 32;

   // Single-precision significands sit in sig[SGW-1:0] at stage 1.
   typedef struct packed {
      logic            inc;
      logic [SIGW-1:0] sig;
      logic            inexact;
      logic            sign;
      logic            db;
   } s1_t;

   typedef struct packed {
      logic [SIGW-1:0] f3;
      logic            sigovf;
      logic            inexact;
      logic            sign;
      logic            db;
   } s2_t;

endpackage

// File: rtl/rnd_decide.sv
// Round-up decision: picks L/r/s for the active precision and applies the
// rounding mode. Purely combinational.
module rnd_decide
   import rnd_pkg::*;
(
   input  logic [55:0] fn,
   input  logic        db,
   input  logic        sign,
   input  logic [1:0]  rm,
   output logic        inc,
   output logic        inexact
);

   logic lsb;
   logic rbit;
   logic sbit;

   always_comb begin
      if (db) begin
         lsb  = fn[LSB_DB];
         rbit = fn[LSB_DB-1];
         sbit = |fn[LSB_DB-2:0];
      end else begin
         lsb  = fn[LSB_SG];
         rbit = fn[LSB_SG-1];
         sbit = |fn[LSB_SG-2:0];
      end

      inexact = rbit | sbit;

      case (rm_t'(rm))
         RNE:     inc = rbit & (lsb | sbit);
         RZ:      inc = 1'b0;
         RU:      inc = ~sign & inexact;
         RD:      inc = sign & inexact;
         default: inc = 1'b0;
      endcase
   end

endmodule

// File: rtl/sigrnd_pipe.sv
// Two-stage significand rounder with valid/ready on both sides. Stage 1
// registers the round decision, stage 2 the incremented significand.
module sigrnd_pipe
   import rnd_pkg::*;
#(
   parameter int EW = 11
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [EW-1:0] e2,
   input  logic [55:0]   fn,
   input  logic          sign,
   input  logic          db,
   input  logic [1:0]    rm,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [EW-1:0] e2_o,
   output logic [52:0]   f3,
   output logic          sigovf,
   output logic          inexact,
   output logic          db_o,
   output logic          sign_o
);

   logic            inc_p0;
   logic            inexact_p0;
   logic [SIGW-1:0] sig_p0;
   logic            acc_p0;

   logic            vld_p1;
   s1_t             pay_p1;
   logic [EW-1:0]   e2_p1;
   s2_t             rnd_p1;

   logic            vld_p2;
   s2_t             pay_p2;
   logic [EW-1:0]   e2_p2;
   logic            adv_p2;

   // An overflowing carry leaves only the hidden bit set, so f3 becomes 1.000...
   function automatic s2_t round_sig(input s1_t s);
      logic [SIGW:0] sum_d;
      logic [SGW:0]  sum_s;
      s2_t           r;
      sum_d     = {1'b0, s.sig} + {{SIGW{1'b0}}, s.inc};
      sum_s     = {1'b0, s.sig[SGW-1:0]} + {{SGW{1'b0}}, s.inc};
      r.inexact = s.inexact;
      r.sign    = s.sign;
      r.db      = s.db;
      if (s.db) begin
         r.sigovf = sum_d[SIGW];
         r.f3     = sum_d[SIGW] ? {1'b1, {(SIGW-1){1'b0}}} : sum_d[SIGW-1:0];
      end else begin
         r.sigovf = sum_s[SGW];
         r.f3     = {(sum_s[SGW] ? {1'b1, {(SGW-1){1'b0}}} : sum_s[SGW-1:0]),
                     {(SIGW-SGW){1'b0}}};
      end
      return r;
   endfunction

   rnd_decide u_decide (
      .fn      (fn),
      .db      (db),
      .sign    (sign),
      .rm      (rm),
      .inc     (inc_p0),
      .inexact (inexact_p0)
   );

   assign sig_p0   = db ? fn[55:LSB_DB] : {{(SIGW-SGW){1'b0}}, fn[55:LSB_SG]};
   assign adv_p2   = !vld_p2 | out_ready;
   assign in_ready = !vld_p1 | adv_p2;
   assign acc_p0   = in_valid & in_ready;

   // ---- stage 1: capture operand and round decision ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         pay_p1 <= '0;
         e2_p1  <= '0;
      end else begin
         if (in_ready) vld_p1 <= in_valid;
         if (acc_p0) begin
            pay_p1 <= '{inc: inc_p0, sig: sig_p0, inexact: inexact_p0,
                        sign: sign, db: db};
            e2_p1  <= e2;
         end
      end
   end

   always_comb rnd_p1 = round_sig(pay_p1);

   // ---- stage 2: rounded result, held while downstream stalls ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2 <= 1'b0;
         pay_p2 <= '0;
         e2_p2  <= '0;
      end else if (adv_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            pay_p2 <= rnd_p1;
            e2_p2  <= e2_p1;
         end
      end
   end

   assign out_valid = vld_p2;
   assign e2_o      = e2_p2;
   assign f3        = pay_p2.f3;
   assign sigovf    = pay_p2.sigovf;
   assign inexact   = pay_p2.inexact;
   assign db_o      = pay_p2.db;
   assign sign_o    = pay_p2.sign;

endmodule

// File: tb/tb_sigrnd_pipe.sv
// Bench for sigrnd_pipe: directed rounding cases, backpressure, reset
// mid-flight, and a randomized run scored against a reference model.
module tb_sigrnd_pipe;

   typedef struct packed {
      logic [10:0] e2;
      logic [52:0] f3;
      logic        sigovf;
      logic        inexact;
      logic        db;
      logic        sign;
   } exp_t;

   localparam logic [1:0] M_RNE = 2'b00;
   localparam logic [1:0] M_RZ  = 2'b01;
   localparam logic [1:0] M_RU  = 2'b10;
   localparam logic [1:0] M_RD  = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] e2;
   logic [55:0] fn;
   logic        sign;
   logic        db;
   logic [1:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] e2_o;
   logic [52:0] f3;
   logic        sigovf;
   logic        inexact;
   logic        db_o;
   logic        sign_o;

   exp_t        dut_out;
   exp_t        sbq[$];
   exp_t        mon_exp;
   int          errors = 0;
   int          checks = 0;

   sigrnd_pipe #(.EW(11)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .e2        (e2),
      .fn        (fn),
      .sign      (sign),
      .db        (db),
      .rm        (rm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .e2_o      (e2_o),
      .f3        (f3),
      .sigovf    (sigovf),
      .inexact   (inexact),
      .db_o      (db_o),
      .sign_o    (sign_o)
   );

   always #5 clk = ~clk;

   assign dut_out = {e2_o, f3, sigovf, inexact, db_o, sign_o};

   // Reference: compares the discarded tail against one half ulp.
   function automatic exp_t model(input logic [55:0] f, input logic d,
                                  input logic sg, input logic [1:0] m,
                                  input logic [10:0] e);
      longint unsigned t, rem, half;
      logic            up;
      exp_t            x;
      if (d) begin
         t = 64'(f[55:3]); rem = 64'(f[2:0]); half = 64'd4;
      end else begin
         t = 64'(f[55:32]); rem = 64'(f[31:0]); half = 64'h8000_0000;
      end
      case (m)
         M_RNE:   up = (rem > half) || (rem == half && t[0]);
         M_RZ:    up = 1'b0;
         M_RU:    up = (rem != 0) && !sg;
         default: up = (rem != 0) && sg;
      endcase
      t = t + 64'(up);
      x.e2      = e;
      x.inexact = (rem != 0);
      x.db      = d;
      x.sign    = sg;
      if (d) begin
         x.sigovf = (t == 64'h20_0000_0000_0000);
         x.f3     = x.sigovf ? 53'h10_0000_0000_0000 : t[52:0];
      end else begin
         x.sigovf = (t == 64'h100_0000);
         x.f3     = {(x.sigovf ? 24'h80_0000 : t[23:0]), 29'b0};
      end
      return x;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got %h, want no result", dut_out);
         end else begin
            mon_exp = sbq.pop_front();
            if (dut_out !== mon_exp) begin
               errors++;
               $display("FAIL sb_result: got %h, want %h", dut_out, mon_exp);
            end
         end
      end
   end

   // Drives one operand, then waits for out_valid; lat counts negedges
   // from the accept edge to out_valid (0 = timed out).
   task automatic xact(input logic [55:0] f, input logic d, input logic sg,
                       input logic [1:0] m, input logic [10:0] e, output int lat);
      bit acc;
      fn = f; db = d; sign = sg; rm = m; e2 = e; in_valid = 1'b1;
      acc = 1'b0;
      lat = 0;
      for (int i = 0; i < 10 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sbq.push_back(model(f, d, sg, m, e));
            acc = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      fn = 'x;
      if (!acc) return;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (out_valid) lat = i;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      fn = '0; e2 = '0; sign = 1'b0; db = 1'b0; rm = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid: got %b, want 0", out_valid);
      end
      checks++;
      if (dut_out !== '0) begin
         errors++; $display("FAIL rst_data: got %h, want 0", dut_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_dbl_ovf;
      int lat;
      out_ready = 1'b1;
      xact({53'h1F_FFFF_FFFF_FFFF, 3'b100}, 1'b1, 1'b0, M_RNE, 11'h3FF, lat);
      checks++;
      if (lat != 2 || sigovf !== 1'b1 || f3 !== 53'h10_0000_0000_0000 ||
          inexact !== 1'b1 || e2_o !== 11'h3FF) begin
         errors++;
         $display("FAIL dbl_ovf: lat=%0d sigovf=%b f3=%h inexact=%b e2_o=%h, want lat=2 sigovf=1 f3=10000000000000 inexact=1 e2_o=3ff",
                  lat, sigovf, f3, inexact, e2_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_rne_ties;
      logic [3:0]  lows [3] = '{4'b0100, 4'b1100, 4'b0000};
      logic        incs [3] = '{1'b0, 1'b1, 1'b0};
      logic        inxs [3] = '{1'b1, 1'b1, 1'b0};
      logic [55:0] f;
      logic [52:0] want;
      int          lat;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         f    = {52'hC5A3F01E7B92D, lows[i]};
         want = f[55:3] + 53'(incs[i]);
         xact(f, 1'b1, 1'b0, M_RNE, 11'h123, lat);
         checks++;
         if (lat == 0 || f3 !== want || inexact !== inxs[i] || sigovf !== 1'b0) begin
            errors++;
            $display("FAIL rne_tie[%0d]: f3=%h inexact=%b, want f3=%h inexact=%b",
                     i, f3, inexact, want, inxs[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_modes;
      logic [1:0]  ms   [6] = '{M_RU, M_RU, M_RD, M_RD, M_RZ, M_RZ};
      logic        sgs  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        incs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [55:0] f;
      logic [52:0] want;
      int          lat;
      out_ready = 1'b1;
      f = {52'hC5A3F01E7B92D, 4'b0001};
      for (int i = 0; i < 6; i++) begin
         want = f[55:3] + 53'(incs[i]);
         xact(f, 1'b1, sgs[i], ms[i], 11'h200, lat);
         checks++;
         if (lat == 0 || f3 !== want || inexact !== 1'b1 || sign_o !== sgs[i]) begin
            errors++;
            $display("FAIL mode[%0d]: f3=%h inexact=%b sign_o=%b, want f3=%h inexact=1 sign_o=%b",
                     i, f3, inexact, sign_o, want, sgs[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_single;
      logic [52:0] top;
      int          lat;
      top = {1'b1, 52'b0};
      out_ready = 1'b1;
      xact({24'hFF_FFFF, 1'b1, 31'h0}, 1'b0, 1'b0, M_RNE, 11'h07F, lat);
      checks++;
      if (lat == 0 || sigovf !== 1'b1 || f3 !== top || f3[28:0] !== 29'b0 ||
          inexact !== 1'b1 || db_o !== 1'b0) begin
         errors++;
         $display("FAIL sgl_ovf: sigovf=%b f3=%h inexact=%b, want sigovf=1 f3=%h inexact=1",
                  sigovf, f3, inexact, top);
      end
      @(posedge clk); #1;
      xact({24'hFF_FFFF, 32'h0}, 1'b0, 1'b0, M_RNE, 11'h07F, lat);
      checks++;
      if (lat == 0 || sigovf !== 1'b0 || f3[52:29] !== 24'hFF_FFFF ||
          f3[28:0] !== 29'b0 || inexact !== 1'b0) begin
         errors++;
         $display("FAIL sgl_exact: sigovf=%b f3=%h inexact=%b, want sigovf=0 f3=1fffffe0000000 inexact=0",
                  sigovf, f3, inexact);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      logic [63:0] w;
      logic [55:0] f;
      for (int i = 0; i < 80; i++) begin
         out_ready = ($urandom % 4) != 0;
         if (($urandom % 4) != 0) begin
            w = {$urandom, $urandom};
            f = w[55:0];
            case ($urandom % 6)
               0: f[2:0]  = 3'b100;
               1: f[31:0] = 32'h8000_0000;
               2: f[55:3] = '1;
               3: f[55:32] = '1;
               default: ;
            endcase
            fn = f; db = 1'($urandom); sign = 1'($urandom);
            rm = 2'($urandom); e2 = 11'($urandom); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0; fn = 'x;
         end
         @(negedge clk);
         if (in_valid && in_ready) sbq.push_back(model(fn, db, sign, rm, e2));
         @(posedge clk); #1;
      end
      in_valid = 1'b0; fn = 'x; out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL rand_drain: %0d results outstanding, want 0", sbq.size());
      end
   endtask

   task automatic test_back_to_back;
      logic [55:0] bf [3] = '{56'hF0_0000_0000_000C, 56'hAB_CDEF_8000_0001, 56'h81_2345_6789_ABCD};
      logic        bd [3] = '{1'b1, 1'b0, 1'b1};
      exp_t        eb [3];
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fn = bf[i]; db = bd[i]; sign = 1'b0; rm = M_RNE; e2 = 11'h100 + 11'(i);
         in_valid = 1'b1;
         eb[i] = model(bf[i], bd[i], 1'b0, M_RNE, 11'h100 + 11'(i));
         @(negedge clk);
         checks++;
         if (in_ready !== (i < 2)) begin
            errors++;
            $display("FAIL bp_accept[%0d]: in_ready=%b, want %b", i, in_ready, (i < 2));
         end
         if (in_valid && in_ready) sbq.push_back(eb[i]);
         @(posedge clk); #1;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_out !== eb[0]) begin
            errors++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out=%h, want 1 0 %h",
                     k, out_valid, in_ready, dut_out, eb[0]);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || dut_out !== eb[0]) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b out=%h, want 1 1 %h",
                  in_ready, out_valid, dut_out, eb[0]);
      end
      if (in_valid && in_ready) sbq.push_back(eb[2]);
      @(posedge clk); #1;
      in_valid = 1'b0; fn = 'x;
      for (int j = 1; j < 3; j++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || dut_out !== eb[j]) begin
            errors++;
            $display("FAIL bp_order[%0d]: out_valid=%b out=%h, want 1 %h", j, out_valid, dut_out, eb[j]);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_empty: out_valid=%b, want 0", out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midflight;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         fn = {52'h9000000000001, 4'b0110}; db = 1'b1; sign = 1'b0; rm = M_RNE;
         e2 = 11'h055; in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) sbq.push_back(model(fn, db, sign, rm, e2));
         @(posedge clk); #1;
      end
      in_valid = 1'b0; fn = 'x;
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_full: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || dut_out !== '0) begin
         errors++;
         $display("FAIL mid_async: out_valid=%b out=%h, want 0 0", out_valid, dut_out);
      end
      sbq.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after[%0d]: in_ready=%b out_valid=%b, want 1 0", k, in_ready, out_valid);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_dbl_ovf();
      test_rne_ties();
      test_modes();
      test_single();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sigrnd_pipe.md
Name: sigrnd_pipe

Overview:
- Two-stage pipelined significand rounder in the FPU rounder path.
- Sits directly upstream of the exponent-adjust stage and feeds it the rounded significand, the `sigovf` flag and the unmodified exponent `e2`.
- Handles double precision (`db`=1) and single precision (`db`=0) in one datapath, with valid/ready handshakes on both sides.
- Does not increment the exponent; the downstream exponent logic does this, based on `sigovf`.

Parameters:
- EW, 11, exponent width carried through unchanged.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input operand valid.
- `in_ready`  out  1  stage 1 can accept an operand this cycle.
- `e2`  in  EW  normalized exponent; passed through.
- `fn`  in  56  normalized significand.
  - `fn[55]` is the hidden 1.
  - Sticky is pre-folded into `fn[0]`.
- `sign`  in  1  operand sign.
- `db`  in  1  1 = double, 0 = single.
- `rm`  in  2  rounding mode.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `e2_o`  out  EW  exponent, unchanged.
- `f3`  out  53  rounded significand.
  - `f3[52]` is the hidden bit.
  - In single precision, `f3[28:0]` = 0.
- `sigovf`  out  1  rounding carried out of the significand.
- `inexact`  out  1  round or sticky bit nonzero.
- `db_o`, `sign_o`  out  1 each  pass-through.

Behaviour:
- Reset (async, `rst_n`=0):
  - Stage-valid bits v1 = v2 = 0, hence `out_valid` = 0.
  - All data registers = 0: `e2_o`, `f3`, `sigovf`, `inexact`, `db_o`, `sign_o` read 0.
  - `in_ready` = 1 from the first clock after release.
- Bit extraction:
  - Double: L = `fn[3]`, r = `fn[2]`, s = `|fn[1:0]`, significand = `fn[55:3]`.
  - Single: L = `fn[32]`, r = `fn[31]`, s = `|fn[30:0]`, significand = `fn[55:32]`.
- Stage 1 registers: inc, significand field, r|s, `e2`, `sign`, `db`.
  - inc by `rm`:
    - RNE (00): r&(L|s).
    - RZ (01): 0.
    - RU (10): ~sign&(r|s).
    - RD (11): sign&(r|s).
- Stage 2 (double):
  - sum54 = {0, sig53} + inc.
  - `sigovf` = sum54[53].
  - `f3` = `sigovf` ? {1, 52'b0} : sum54[52:0].
- Stage 2 (single):
  - sum25 = {0, sig24} + inc.
  - `sigovf` = sum25[24].
  - `f3` = {(`sigovf` ? {1, 23'b0} : sum25[23:0]), 29'b0}.
- `inexact` = r|s, independent of `rm`.
- Latency: 2 cycles, accept edge to `out_valid`, with no backpressure. Throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid & ready on a rising edge.
  - Stage 2 advances when !v2 | `out_ready`.
  - `in_ready` = !v1 | (!v2 | `out_ready`); combinational, from registered state and `out_ready`.
  - While `out_valid`=1 and `out_ready`=0, all outputs hold stable.
  - Results leave in order, with no loss or duplication.
- Simultaneous accept and drain in the same cycle: both happen; stage contents shift.
- Full (v1 = v2 = 1 with `out_ready` = 0): `in_ready` = 0; inputs are ignored.
- Reset mid-operation: in-flight operands are discarded and no partial result appears.
- Inputs are sampled only on accepted cycles; X on unaccepted inputs must not propagate.

Decomposition:
- Package `rnd_pkg`:
  - `rm_t` enum: RNE, RZ, RU, RD.
  - Constants for the double/single LSB positions (3, 32) and `SIGW`=53.
  - Stage payload struct typedefs.
- One combinational sub-module, `rnd_decide`: (`fn`, `db`, `sign`, `rm`) -> (inc, inexact).
- The pipeline and handshake logic stays in `sigrnd_pipe`.

Test Plan:
- Double, RNE, `fn[55:3]` all ones, `fn[2:0]`=100, `e2`=0x3FF:
  - `sigovf`=1, `f3`=0x10000000000000, `inexact`=1, `e2_o`=0x3FF.
  - Output appears 2 cycles after accept.
- Double, RNE ties:
  - `fn[3:0]`=0100 -> no increment.
  - `fn[3:0]`=1100 -> `f3` LSB incremented by 1.
  - `fn[3:0]`=0000 -> `inexact`=0.
- Directed modes with `fn[2:0]`=001:
  - RU, `sign`=0 -> inc.
  - RU, `sign`=1 -> no inc.
  - RD, `sign`=1 -> inc.
  - RZ -> never inc.
  - All four cases: `inexact`=1.
- Single, `fn[55:32]`=0xFFFFFF, `fn[31]`=1, RNE:
  - `sigovf`=1, `f3`={1, 52'b0}, `f3[28:0]`=0.
  - Repeat with `fn[31:0]`=0: `sigovf`=0, `f3[52:29]`=0xFFFFFF.
- Backpressure:
  - Hold `out_ready`=0 and present 3 operands back-to-back: only 2 accepted, then `in_ready`=0, outputs stable.
  - Release `out_ready`: results emerge in order, one per cycle; the third operand is accepted on the release cycle.
- Reset mid-flight:
  - Assert `rst_n`=0 asynchronously with v1 = v2 = 1: `out_valid` drops to 0 immediately, without waiting for a clock edge.
  - After release: `in_ready`=1 and no stale result appears.
